// File: rtl/uart_cmd_decoder.sv
// Framed write-command decoder behind a UART receiver: SYNC, ADDR, LEN, payload, XOR checksum.
// Optional saturating frame-error counter on o_Err_Count when UART_CMD_ERR_CNT_EN is defined.
module uart_cmd_decoder #(
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned TIMEOUT_CLKS = 100000,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Wr_En,
  output logic [7:0] o_Wr_Addr,
  output logic [7:0] o_Wr_Data,
  input  logic       i_Wr_Ready,
  output logic       o_Frame_Done,
  output logic       o_Frame_Err,
  output logic [1:0] o_Err_Code,
`ifdef UART_CMD_ERR_CNT_EN
  output logic [7:0] o_Err_Count,
`endif
  output logic       o_Busy
);

  localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CLKS - 1);
  localparam logic [8:0] LMAX = 9'(MAX_LEN);
  localparam logic [1:0] ERR_CKSUM   = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_PAYLOAD, S_CKSUM, S_CHECK, S_WRITE
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      idx_q, idx_d;
  logic [7:0]      acc_q, acc_d;
  logic [7:0]      cks_q, cks_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            wr_en_q, wr_en_d;
  logic [7:0]      wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic            busy_q, busy_d;
  logic [7:0]      mem_q [MAX_LEN];

  // Payload buffer; contents are don't-care out of reset
  always_ff @(posedge i_Clock) begin
    if (state_q == S_PAYLOAD && i_Rx_DV) mem_q[IW'(idx_q)] <= i_Rx_Byte;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
      cks_q      <= '0;
      tcnt_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      cks_q      <= cks_d;
      tcnt_q     <= tcnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    cks_d      = cks_q;
    tcnt_d     = tcnt_q;
    wr_en_d    = wr_en_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    case (state_q)
      S_IDLE: begin
        if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) begin
          state_d = S_ADDR;
          tcnt_d  = '0;
        end
      end
      S_ADDR, S_LEN, S_PAYLOAD, S_CKSUM: begin
        // A byte on the expiry cycle takes priority over the timeout
        if (i_Rx_DV) begin
          tcnt_d = '0;
          case (state_q)
            S_ADDR: begin
              addr_d  = i_Rx_Byte;
              acc_d   = i_Rx_Byte;
              state_d = S_LEN;
            end
            S_LEN: begin
              if (i_Rx_Byte == 8'd0 || {1'b0, i_Rx_Byte} > LMAX) begin
                err_d      = 1'b1;
                err_code_d = ERR_LEN;
                state_d    = S_IDLE;
              end else begin
                len_d   = i_Rx_Byte;
                acc_d   = acc_q ^ i_Rx_Byte;
                idx_d   = '0;
                state_d = S_PAYLOAD;
              end
            end
            S_PAYLOAD: begin
              acc_d = acc_q ^ i_Rx_Byte;
              if (idx_q == len_q - 8'd1) state_d = S_CKSUM;
              else idx_d = idx_q + 8'd1;
            end
            default: begin
              cks_d   = i_Rx_Byte;
              state_d = S_CHECK;
            end
          endcase
        end else if (tcnt_q == TMAX) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_CHECK: begin
        if (cks_q == acc_q) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = mem_q[0];
          idx_d     = '0;
          state_d   = S_WRITE;
        end else begin
          err_d      = 1'b1;
          err_code_d = ERR_CKSUM;
          state_d    = S_IDLE;
        end
      end
      S_WRITE: begin
        if (wr_en_q && i_Wr_Ready) begin
          if (idx_q == len_q - 8'd1) begin
            wr_en_d = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d     = idx_q + 8'd1;
            wr_addr_d = wr_addr_q + 8'd1;
            wr_data_d = mem_q[IW'(idx_q + 8'd1)];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

`ifdef UART_CMD_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) err_cnt_q <= '0;
    else         err_cnt_q <= err_cnt_d;
  end

  assign o_Err_Count = err_cnt_q;
`endif

  assign o_Wr_En      = wr_en_q;
  assign o_Wr_Addr    = wr_addr_q;
  assign o_Wr_Data    = wr_data_q;
  assign o_Frame_Done = done_q;
  assign o_Frame_Err  = err_q;
  assign o_Err_Code   = err_code_q;
  assign o_Busy       = busy_q;

endmodule
